// File: rtl/mouse_cursor_tracker_pkg.sv
// Package mouse_pkg: shared widths, FSM state encoding, skid-buffer entry type and the
// delta sign-extend/scale helper used by the cursor tracker.
package mouse_pkg;

    localparam int unsigned DELTA_W = 9;   // PS/2 delta: sign flag + 8-bit byte
    localparam int unsigned SUM_W   = 12;  // signed arithmetic width for position sums
    localparam int unsigned POS_W   = 10;  // absolute cursor coordinate width

    // FSM state encoding
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CALC_X = 2'd1;
    localparam logic [1:0] CALC_Y = 2'd2;
    localparam logic [1:0] COMMIT = 2'd3;

    // One buffered movement packet, raw 9-bit two's complement deltas
    typedef struct packed {
        logic [DELTA_W-1:0] dx;
        logic [DELTA_W-1:0] dy;
    } skid_entry_t;

    // Sign-extend a 9-bit delta to SUM_W bits, then arithmetic shift right by sh.
    function automatic logic signed [SUM_W-1:0] delta_ext(input logic [DELTA_W-1:0] d,
                                                          input int unsigned sh);
        logic signed [SUM_W-1:0] ext;
        ext = $signed({{(SUM_W - DELTA_W){d[DELTA_W-1]}}, d});
        return ext >>> sh;
    endfunction

endpackage

// File: rtl/mouse_cursor_tracker_if.sv
// Interface between the PS/2 packet front end and the cursor tracker.
//  master: packet producer / cursor consumer (drives packets, reads cursor state)
//  slave : mouse_cursor_tracker
//  pkt_valid, vertical, ver_flag, horizontal, hor_flag, recenter : producer -> tracker
//  cursor_x, cursor_y, moved, busy, drop_cnt                     : tracker -> consumer
interface mouse_cursor_tracker_if;
    import mouse_pkg::*;

    logic             pkt_valid;
    logic [7:0]       vertical;
    logic             ver_flag;
    logic [7:0]       horizontal;
    logic             hor_flag;
    logic             recenter;
    logic [POS_W-1:0] cursor_x;
    logic [POS_W-1:0] cursor_y;
    logic             moved;
    logic             busy;
    logic [7:0]       drop_cnt;

    modport master (
        output pkt_valid, vertical, ver_flag, horizontal, hor_flag, recenter,
        input  cursor_x, cursor_y, moved, busy, drop_cnt
    );

    modport slave (
        input  pkt_valid, vertical, ver_flag, horizontal, hor_flag, recenter,
        output cursor_x, cursor_y, moved, busy, drop_cnt
    );

endinterface

// File: rtl/mouse_axis_clamp.sv
// mouse_axis_clamp: adds a signed delta to an absolute coordinate and saturates the result
// to 0..lim. Combinational.
//  pos   in  POS_W  current coordinate
//  delta in  SUM_W  signed delta (already scaled / direction-corrected)
//  lim   in  POS_W  largest legal coordinate (resolution - 1)
//  res   out POS_W  saturated coordinate
// The limit is a runtime input because a single instance serves both axes; RES is the
// largest resolution the instance must support.
module mouse_axis_clamp
    import mouse_pkg::*;
#(
    parameter int unsigned RES = 1024
) (
    input  logic [POS_W-1:0]        pos,
    input  logic signed [SUM_W-1:0] delta,
    input  logic [POS_W-1:0]        lim,
    output logic [POS_W-1:0]        res
);

    if (RES > (1 << POS_W)) begin : gen_res_check
        $error("mouse_axis_clamp: RES exceeds coordinate width");
    end

    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] lim_ext;

    assign sum     = $signed({{(SUM_W - POS_W){1'b0}}, pos}) + delta;
    assign lim_ext = $signed({{(SUM_W - POS_W){1'b0}}, lim});

    always_comb begin
        if (sum[SUM_W-1]) begin
            res = '0;
        end else if (sum > lim_ext) begin
            res = lim;
        end else begin
            res = sum[POS_W-1:0];
        end
    end

endmodule

// File: rtl/mouse_cursor_tracker.sv
// mouse_cursor_tracker: integrates decoded PS/2 movement packets into an absolute,
// display-saturated cursor position.
//  clk  in  system clock
//  rst  in  synchronous reset, active-low
//  bus  slave modport of mouse_cursor_tracker_if:
//       pkt_valid/vertical/ver_flag/horizontal/hor_flag : packet strobe and deltas
//       (ver_* is the PS/2 X axis, hor_* the PS/2 Y axis, +Y is upward)
//       recenter : force cursor to (X_INIT, Y_INIT)
//       cursor_x/cursor_y : position, moved : update strobe, busy : packet in flight,
//       drop_cnt : saturating count of packets lost to a full skid buffer
// Optional feature: define MOUSE_CURSOR_ACCEL_EN to double any post-shift delta whose
// magnitude exceeds ACCEL_THRESH.
// Sequence per packet: IDLE -> CALC_X -> CALC_Y -> COMMIT -> IDLE; moved pulses in the
// cycle after COMMIT. A 1-entry skid buffer absorbs one packet arriving while busy.
module mouse_cursor_tracker
    import mouse_pkg::*;
#(
    parameter int unsigned H_RES        = 640,
    parameter int unsigned V_RES        = 480,
    parameter int unsigned X_INIT       = 320,
    parameter int unsigned Y_INIT       = 240,
    parameter int unsigned SHIFT        = 0,
    parameter int unsigned ACCEL_THRESH = 16
) (
    input logic                  clk,
    input logic                  rst,
    mouse_cursor_tracker_if.slave bus
);

    if (H_RES > 1024 || V_RES > 1024 || SHIFT > 3 || ACCEL_THRESH > 1023)
    begin : gen_param_check
        $error("mouse_cursor_tracker: parameter out of range");
    end

    localparam int unsigned MAX_RES = (H_RES > V_RES) ? H_RES : V_RES;
    localparam logic [POS_W-1:0] H_MAX = POS_W'(H_RES - 1);
    localparam logic [POS_W-1:0] V_MAX = POS_W'(V_RES - 1);
    localparam logic [POS_W-1:0] X_RST = POS_W'(X_INIT);
    localparam logic [POS_W-1:0] Y_RST = POS_W'(Y_INIT);

    logic [1:0]       state_q, state_d;
    skid_entry_t      ops_q, ops_d;
    skid_entry_t      skid_q, skid_d;
    logic             skid_vld_q, skid_vld_d;
    logic [POS_W-1:0] next_x_q, next_x_d;
    logic [POS_W-1:0] next_y_q, next_y_d;
    logic [POS_W-1:0] cursor_x_q, cursor_x_d;
    logic [POS_W-1:0] cursor_y_q, cursor_y_d;
    logic             moved_q, moved_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;

    skid_entry_t pkt_in;
    assign pkt_in.dx = {bus.ver_flag, bus.vertical};
    assign pkt_in.dy = {bus.hor_flag, bus.horizontal};

    // Delta scaling
    logic signed [SUM_W-1:0] dx_s;
    logic signed [SUM_W-1:0] dy_s;

`ifdef MOUSE_CURSOR_ACCEL_EN
    function automatic logic signed [SUM_W-1:0] accel(input logic signed [SUM_W-1:0] d);
        logic [SUM_W-1:0] mag;
        mag = d[SUM_W-1] ? -d : d;
        return (mag > SUM_W'(ACCEL_THRESH)) ? (d <<< 1) : d;
    endfunction

    assign dx_s = accel(delta_ext(ops_q.dx, SHIFT));
    assign dy_s = accel(delta_ext(ops_q.dy, SHIFT));
`else
    assign dx_s = delta_ext(ops_q.dx, SHIFT);
    assign dy_s = delta_ext(ops_q.dy, SHIFT);
`endif

    // Shared clamp: X in CALC_X, Y in CALC_Y (screen Y grows downward, so dy is negated)
    logic                    sel_y;
    logic [POS_W-1:0]        clamp_pos;
    logic signed [SUM_W-1:0] clamp_delta;
    logic [POS_W-1:0]        clamp_lim;
    logic [POS_W-1:0]        clamp_res;

    assign sel_y       = (state_q == CALC_Y);
    assign clamp_pos   = sel_y ? cursor_y_q : cursor_x_q;
    assign clamp_delta = sel_y ? -dy_s : dx_s;
    assign clamp_lim   = sel_y ? V_MAX : H_MAX;

    mouse_axis_clamp #(
        .RES (MAX_RES)
    ) u_clamp (
        .pos   (clamp_pos),
        .delta (clamp_delta),
        .lim   (clamp_lim),
        .res   (clamp_res)
    );

    always_comb begin
        state_d    = state_q;
        ops_d      = ops_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        next_x_d   = next_x_q;
        next_y_d   = next_y_q;
        cursor_x_d = cursor_x_q;
        cursor_y_d = cursor_y_q;
        moved_d    = 1'b0;
        drop_cnt_d = drop_cnt_q;

        if (bus.recenter) begin
            // Any packet arriving together with recenter is discarded silently
            cursor_x_d = X_RST;
            cursor_y_d = Y_RST;
            skid_vld_d = 1'b0;
            state_d    = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (skid_vld_q) begin
                        // Buffered packet goes first; a new arrival refills the buffer
                        ops_d      = skid_q;
                        state_d    = CALC_X;
                        skid_vld_d = bus.pkt_valid;
                        if (bus.pkt_valid) begin
                            skid_d = pkt_in;
                        end
                    end else if (bus.pkt_valid) begin
                        ops_d   = pkt_in;
                        state_d = CALC_X;
                    end
                end
                CALC_X: begin
                    next_x_d = clamp_res;
                    state_d  = CALC_Y;
                end
                CALC_Y: begin
                    next_y_d = clamp_res;
                    state_d  = COMMIT;
                end
                default: begin  // COMMIT
                    cursor_x_d = next_x_q;
                    cursor_y_d = next_y_q;
                    moved_d    = 1'b1;
                    state_d    = IDLE;
                end
            endcase

            if (state_q != IDLE && bus.pkt_valid) begin
                if (!skid_vld_q) begin
                    skid_d     = pkt_in;
                    skid_vld_d = 1'b1;
                end else if (drop_cnt_q != 8'hFF) begin
                    drop_cnt_d = drop_cnt_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            ops_q      <= '0;
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
            next_x_q   <= X_RST;
            next_y_q   <= Y_RST;
            cursor_x_q <= X_RST;
            cursor_y_q <= Y_RST;
            moved_q    <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            ops_q      <= ops_d;
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
            next_x_q   <= next_x_d;
            next_y_q   <= next_y_d;
            cursor_x_q <= cursor_x_d;
            cursor_y_q <= cursor_y_d;
            moved_q    <= moved_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.cursor_x = cursor_x_q;
    assign bus.cursor_y = cursor_y_q;
    assign bus.moved    = moved_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_mouse_cursor_tracker.sv
// Directed bench for mouse_cursor_tracker (default parameters, SHIFT=0).
module tb_mouse_cursor_tracker;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    mouse_cursor_tracker_if bus ();

    mouse_cursor_tracker #(
        .H_RES        (640),
        .V_RES        (480),
        .X_INIT       (320),
        .Y_INIT       (240),
        .SHIFT        (0),
        .ACCEL_THRESH (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_pkt(input logic [8:0] dx, input logic [8:0] dy);
        {bus.ver_flag, bus.vertical}   = dx;
        {bus.hor_flag, bus.horizontal} = dy;
    endtask

    // One-cycle packet strobe
    task automatic send(input logic [8:0] dx, input logic [8:0] dy);
        set_pkt(dx, dy);
        bus.pkt_valid = 1'b1;
        tick();
        bus.pkt_valid = 1'b0;
    endtask

    task automatic do_recenter();
        bus.recenter = 1'b1;
        tick();
        bus.recenter = 1'b0;
    endtask

    // Bounded wait for the moved strobe
    task automatic wait_moved(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.moved) begin
                seen = 1'b1;
                break;
            end
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    task automatic count_moved(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (bus.moved) cnt++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b0;
        bus.pkt_valid = 1'b0;
        bus.recenter  = 1'b0;
        set_pkt(9'd0, 9'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // 1. reset state
        check("rst_x", 32'(bus.cursor_x), 32'd320);
        check("rst_y", 32'(bus.cursor_y), 32'd240);
        check("rst_moved", 32'(bus.moved), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_drop", 32'(bus.drop_cnt), 32'd0);

        // 2. +10 X, +5 Y (up) with exact latency
        send(9'h00A, 9'h005);
        check("t2_busy", 32'(bus.busy), 32'd1);
        tick();
        tick();
        check("t2_moved_early", 32'(bus.moved), 32'd0);
        tick();
        check("t2_moved", 32'(bus.moved), 32'd1);
        check("t2_x", 32'(bus.cursor_x), 32'd330);
        check("t2_y", 32'(bus.cursor_y), 32'd235);
        check("t2_busy_done", 32'(bus.busy), 32'd0);
        tick();
        check("t2_moved_pulse", 32'(bus.moved), 32'd0);

        // 3. left clamp and bottom clamp
        do_recenter();
        check("rc_x", 32'(bus.cursor_x), 32'd320);
        send(9'h138, 9'h000);  // dx = -200
        wait_moved("t3a_moved");
        check("t3a_x", 32'(bus.cursor_x), 32'd120);
        send(9'h138, 9'h000);
        wait_moved("t3b_moved");
        check("t3b_x", 32'(bus.cursor_x), 32'd0);
        send(9'h000, 9'h101);  // dy = -255 -> screen down
        wait_moved("t3c_moved");
        check("t3c_y", 32'(bus.cursor_y), 32'd479);
        check("t3c_x", 32'(bus.cursor_x), 32'd0);

        // right and top clamp
        do_recenter();
        send(9'h0FF, 9'h0FF);
        wait_moved("t3d_moved");
        check("t3d_x", 32'(bus.cursor_x), 32'd575);
        check("t3d_y", 32'(bus.cursor_y), 32'd0);
        send(9'h0FF, 9'h000);
        wait_moved("t3e_moved");
        check("t3e_x", 32'(bus.cursor_x), 32'd639);

        // zero delta still pulses moved
        send(9'h000, 9'h000);
        wait_moved("zero_moved");
        check("zero_x", 32'(bus.cursor_x), 32'd639);
        check("zero_y", 32'(bus.cursor_y), 32'd0);

        // 4. three back-to-back packets: one buffered, one dropped
        do_recenter();
        set_pkt(9'h001, 9'h000);
        bus.pkt_valid = 1'b1;
        tick();
        tick();
        tick();
        bus.pkt_valid = 1'b0;
        count_moved(12, cnt);
        check("t4_pulses", 32'(cnt), 32'd2);
        check("t4_x", 32'(bus.cursor_x), 32'd322);
        check("t4_y", 32'(bus.cursor_y), 32'd240);
        check("t4_drop", 32'(bus.drop_cnt), 32'd1);

        // 5. recenter with a full skid buffer and a simultaneous packet
        set_pkt(9'h005, 9'h000);
        bus.pkt_valid = 1'b1;
        tick();
        tick();
        bus.recenter = 1'b1;
        tick();
        bus.pkt_valid = 1'b0;
        bus.recenter  = 1'b0;
        check("t5_x", 32'(bus.cursor_x), 32'd320);
        check("t5_y", 32'(bus.cursor_y), 32'd240);
        check("t5_moved", 32'(bus.moved), 32'd0);
        check("t5_busy", 32'(bus.busy), 32'd0);
        check("t5_drop", 32'(bus.drop_cnt), 32'd1);
        count_moved(8, cnt);
        check("t5_no_pulse", 32'(cnt), 32'd0);
        check("t5_x_after", 32'(bus.cursor_x), 32'd320);

        // drop counter saturation under continuous packets
        set_pkt(9'h000, 9'h000);
        bus.pkt_valid = 1'b1;
        for (int i = 0; i < 400; i++) tick();
        bus.pkt_valid = 1'b0;
        check("drop_sat", 32'(bus.drop_cnt), 32'd255);
        do_recenter();

        // 6. acceleration threshold
        send(9'h014, 9'h000);  // +20
        wait_moved("t6a_moved");
`ifdef MOUSE_CURSOR_ACCEL_EN
        check("t6a_x", 32'(bus.cursor_x), 32'd360);
`else
        check("t6a_x", 32'(bus.cursor_x), 32'd340);
`endif
        do_recenter();
        send(9'h010, 9'h000);  // +16, at threshold
        wait_moved("t6b_moved");
        check("t6b_x", 32'(bus.cursor_x), 32'd336);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
